// File: rtl/uart_rx_unit.sv
// ============================================================================
// uart_rx_unit : UART receive path, 16x oversampling decoder and byte FIFO
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_rx_unit #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 54,
  parameter int DVSR_BIT = 6,
  parameter int FIFO_W   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_uart,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic                rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [DVSR_BIT-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick;

  logic [1:0]          state_q, state_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [DBIT-1:0]     b_q, b_d, b_shift;
  logic                push_req, ferr_req;

  logic [FIFO_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_nxt, rd_nxt;
  logic                empty_q, empty_d, full_q, full_d;
  logic                frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                push_en, pop_en;
  logic [7:0]          mem [DEPTH];

  // Two-flop synchroniser and free-running oversampling tick
  always_comb begin
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    tick       = (tick_cnt_q == DVSR_BIT'(DVSR - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + DVSR_BIT'(1);
  end

  generate
    if (DBIT == 1) begin : g_shift_1
      assign b_shift = rx_s_q;
    end else begin : g_shift_n
      assign b_shift = {rx_s_q, b_q[DBIT-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == S_W'(7)) begin
            // A start bit still low at mid-bit is genuine; otherwise a glitch
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            b_d = b_shift;
            s_d = '0;
            if (n_q == N_W'(DBIT - 1)) state_d = ST_STOP;
            else                       n_d     = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) state_d = ST_IDLE;
          else                          s_d     = s_q + S_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    ferr_req = 1'b0;
    if (state_q == ST_STOP && tick && s_q == S_W'(SB_TICK - 1)) begin
      push_req = rx_s_q;
      ferr_req = !rx_s_q;
    end
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot
  always_comb begin
    pop_en      = rd_uart && !empty_q;
    push_en     = push_req && (!full_q || pop_en);
    overrun_d   = push_req && full_q && !pop_en;
    frame_err_d = ferr_req;
    wr_nxt      = wr_ptr_q + FIFO_W'(1);
    rd_nxt      = rd_ptr_q + FIFO_W'(1);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    empty_d     = empty_q;
    full_d      = full_q;
    case ({push_en, pop_en})
      2'b10: begin
        wr_ptr_d = wr_nxt;
        empty_d  = 1'b0;
        full_d   = (wr_nxt == rd_ptr_q);
      end
      2'b01: begin
        rd_ptr_d = rd_nxt;
        full_d   = 1'b0;
        empty_d  = (rd_nxt == wr_ptr_q);
      end
      2'b11: begin
        wr_ptr_d = wr_nxt;
        rd_ptr_d = rd_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      tick_cnt_q  <= tick_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= 8'(b_q);
  end

  assign r_data    = mem[rd_ptr_q];
  assign rx_empty  = empty_q;
  assign rx_full   = full_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: doc/uart_rx_unit.md
# uart_rx_unit

Receive path of the UART: the counterpart to the transmit path that serialises FIFO bytes onto `tx`. It synchronises the asynchronous `rx` line, generates its own 16x oversampling tick, and decodes start/data/stop frames (LSB first, no parity). It queues received bytes in a small FIFO that the host drains with `rd_uart`. Framing errors and FIFO overruns are reported as single-cycle pulses.

## Interface

- `DBIT`, 8: data bits per frame (1..8).
- `SB_TICK`, 16: oversampling ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `DVSR`, 54: clock cycles per oversampling tick (baud = f_clk / (16·DVSR)).
- `DVSR_BIT`, 6: width of the tick counter; must satisfy 2^DVSR_BIT ≥ DVSR.
- `FIFO_W`, 2: FIFO address width; depth is 2^FIFO_W.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `rd_uart` in 1: pop the FIFO head; ignored when `rx_empty` = 1.
- `r_data` out 8: FIFO head (show-ahead), `DBIT` bits right-aligned, upper bits 0; valid only when `rx_empty` = 0.
- `rx_empty` out 1: FIFO empty.
- `rx_full` out 1: FIFO full.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `overrun` out 1: one-cycle pulse, completed byte dropped because the FIFO was full.

## Operation

- Synchroniser: two flops on `rx`, both reset to 1. The FSM sees only `rx_s`.
- Tick generator: free-running counter 0..DVSR-1. `tick` is high for one cycle when count = DVSR-1, then the counter wraps to 0. The counter is never restarted by frame activity.
- FSM registers: state, `s` (4-bit tick count, widened to hold SB_TICK-1), `n` (bit index), `b` (DBIT-bit shift register).
- IDLE: when `rx_s` = 0 (checked every clock, not only on tick), go to START with `s` = 0.
- START, on tick:
  - If `s` = 7 and `rx_s` = 0: go to DATA with `s` = 0, `n` = 0.
  - If `s` = 7 and `rx_s` = 1: glitch. Return to IDLE; nothing is pushed and no flag is raised.
  - Otherwise `s`++.
- DATA, on tick:
  - If `s` = 15: `b` ← {`rx_s`, `b`[DBIT-1:1]}, `s` = 0. If `n` = DBIT-1, go to STOP; else `n`++.
  - Otherwise `s`++.
- STOP, on tick:
  - If `s` = SB_TICK-1, return to IDLE and evaluate `rx_s`:
    - `rx_s` = 1: push `b` into the FIFO, or pulse `overrun` if full.
    - `rx_s` = 0: pulse `frame_err`; nothing is pushed.
  - Otherwise `s`++.
- FIFO: 2^FIFO_W × 8 memory with read/write pointers that wrap modulo depth. The memory itself is not reset. `r_data` = mem[rd_ptr], combinational.
  - Push when not full: write and advance `wr_ptr`.
  - Push when full with no pop: drop the byte and pulse `overrun`.
  - Push and pop in the same cycle when full: both succeed, `rx_full` stays 1, no `overrun`.
  - Push and pop in the same cycle when empty: pop is ignored, push succeeds.
  - Pop when empty: no effect, pointers unchanged.

## Timing

- Reset values: `rx_empty` = 1, `rx_full` = 0, `frame_err` = 0, `overrun` = 0, FSM = IDLE, both synchroniser flops = 1, tick counter = 0. `r_data` is don't-care while `rx_empty` = 1.
- Reset asserted mid-frame: everything above is restored immediately (asynchronously), the FIFO is emptied, and the partial byte is discarded.
- `rx` to `rx_s` latency: 2 clocks.
- Frame length in ticks from the start edge: 8 + 16·DBIT + SB_TICK.
- The push happens on the clock of the final STOP tick. `rx_empty` falls and the new `r_data` is visible on the next cycle.
- `frame_err` and `overrun` are high for exactly the clock after the final STOP tick.
- `rd_uart` pops on the clock edge where it is sampled high. `rx_empty` and `rx_full` update on the following cycle.
- `rx_full` rises the cycle after the push that fills the FIFO.
- A new start edge is accepted on the first clock after the return to IDLE, so back-to-back frames with a single stop bit are received without loss.

## Test plan

All scenarios use DVSR = 4, DVSR_BIT = 3 (tick every 4 clocks, one bit = 64 clocks), and DBIT = 8, SB_TICK = 16, FIFO_W = 2 unless stated.

- Reset: hold `reset` low with `rx` toggling → `rx_empty` = 1, `rx_full` = 0, `frame_err` = 0, `overrun` = 0 throughout. Release reset → no byte is ever pushed.
- Single frame 0xA5 (8N1) → `rx_empty` falls within 2 clocks + one tick after the end of the stop bit, `r_data` = 0xA5. One-cycle `rd_uart` → `rx_empty` = 1 on the next cycle.
- Glitch: drive `rx` low for 12 clocks → FSM returns to IDLE, no push, no flags. Then send 0x3C → `r_data` = 0x3C.
- Framing error: send 0x55 with the stop bit held low → single-cycle `frame_err`, `rx_empty` stays 1. A following valid 0x0F is received correctly.
- Overrun: send 0x01..0x05 back-to-back with no reads → `rx_full` = 1 after 0x04, single-cycle `overrun` at the end of 0x05. Four reads return 0x01, 0x02, 0x03, 0x04, then `rx_empty` = 1. Repeat with `rd_uart` pulsed on the exact push cycle of 0x05 while full → no `overrun`, and reads return 0x02..0x05.
- Reset mid-frame: pull `reset` low during data bit 3 of 0xFF → FIFO empty, FSM in IDLE. After release, send 0x81 → only 0x81 appears in the FIFO.
